// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, IF/ID latch, stall counter
// Redirects outrank hazard holds and always flush IF/ID; reset outranks everything.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [4:0]  if_id_rs,
  output logic [4:0]  if_id_rt,
  output logic [15:0] stall_count
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic        pc_hold;

  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    redirect      = branch_taken | jump;
    pc_hold       = ~pc_write | ~imem_ready;

    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    stall_count_d = stall_count_q;

    if (branch_taken) begin
      pc_d = branch_target & WORD_MASK;
    end else if (jump) begin
      pc_d = jump_target & WORD_MASK;
    end else if (!pc_hold) begin
      pc_d = pc_plus4;
    end

    // A redirect abandons whatever was being fetched, regardless of hazard holds.
    if (redirect) begin
      if_id_instr_d = 32'h0000_0000;
      if_id_pc4_d   = 32'h0000_0000;
      if_id_valid_d = 1'b0;
    end else if (if_id_write) begin
      if (imem_ready) begin
        if_id_instr_d = imem_rdata;
        if_id_pc4_d   = pc_plus4;
        if_id_valid_d = 1'b1;
      end else begin
        if_id_instr_d = 32'h0000_0000;
        if_id_pc4_d   = 32'h0000_0000;
        if_id_valid_d = 1'b0;
      end
    end

    if (!redirect && pc_hold && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= 32'h0000_0000;
      if_id_pc4_q   <= 32'h0000_0000;
      if_id_valid_q <= 1'b0;
      stall_count_q <= 16'h0000;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_rs    = if_id_instr_q[25:21];
  assign if_id_rt    = if_id_instr_q[20:16];
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
// Directed scenarios followed by random traffic, all checked against a cycle-level reference model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic [15:0] stall_count;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .if_id_rs     (if_id_rs),
    .if_id_rt     (if_id_rt),
    .stall_count  (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stalls;
  bit          m_known = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_stalls = 0;
      m_known = 1;
    end else begin
      logic [31:0] old_pc;
      old_pc = m_pc;
      if (branch_taken)                 m_pc = {branch_target[31:2], 2'b00};
      else if (jump)                    m_pc = {jump_target[31:2], 2'b00};
      else if (pc_write && imem_ready)  m_pc = old_pc + 32'd4;
      else                              m_stalls = (m_stalls >= 65535) ? 65535 : m_stalls + 1;

      if (branch_taken || jump) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (if_id_write) begin
        if (imem_ready) begin
          m_instr = imem_rdata; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
        end else begin
          m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic pw, input logic iw, input logic rdy,
                      input logic [31:0] rd, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    reset = rst; pc_write = pw; if_id_write = iw; imem_ready = rdy; imem_rdata = rd;
    branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    #1;
    if (m_known) begin
      check("imem_addr", imem_addr, m_pc);
      check("if_id_rs", {27'h0, if_id_rs}, {27'h0, m_instr[25:21]});
      check("if_id_rt", {27'h0, if_id_rt}, {27'h0, m_instr[20:16]});
    end
    model_edge();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc4", if_id_pc4, m_pc4);
    check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    check("stall_count", {16'h0, stall_count}, m_stalls[31:0]);
  endtask

  task automatic run(input logic pw, input logic iw, input logic rdy, input logic [31:0] rd);
    step(1'b0, pw, iw, rdy, rd, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  logic [31:0] saved_instr, saved_pc4, rdw;
  int          saved_stalls;

  initial begin
    reset = 1'b1; pc_write = 1'b0; if_id_write = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
    @(posedge clk); #1;

    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h40, 1'b1, 32'h80);
    check("reset_pc", pc, 32'h0);
    check("reset_valid", {31'h0, if_id_valid}, 32'h0);
    check("reset_stall", {16'h0, stall_count}, 32'h0);
    check("first_imem_addr", imem_addr, 32'h0);

    for (int k = 1; k <= 3; k++) begin
      rdw = $urandom;
      run(1'b1, 1'b1, 1'b1, rdw);
      check("seq_pc", pc, 32'(4 * k));
      check("seq_pc4", if_id_pc4, 32'(4 * k));
      check("seq_valid", {31'h0, if_id_valid}, 32'h1);
      check("seq_instr", if_id_instr, rdw);
    end

    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_000C);
    run(1'b1, 1'b1, 1'b1, 32'h1234_5678);
    check("pre_hold_pc", pc, 32'h10);
    check("pre_hold_rs", {27'h0, if_id_rs}, 32'h11);
    check("pre_hold_rt", {27'h0, if_id_rt}, 32'h14);
    saved_instr = if_id_instr; saved_pc4 = if_id_pc4; saved_stalls = int'(stall_count);
    run(1'b0, 1'b0, 1'b1, 32'hAAAA_5555);
    run(1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
    check("hold_pc", pc, 32'h10);
    check("hold_instr", if_id_instr, saved_instr);
    check("hold_pc4", if_id_pc4, saved_pc4);
    check("hold_stall", {16'h0, stall_count}, 32'(saved_stalls + 2));

    saved_stalls = int'(stall_count);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    check("br_pc", pc, 32'h100);
    check("br_valid", {31'h0, if_id_valid}, 32'h0);
    check("br_instr", if_id_instr, 32'h0);
    check("br_no_stall", {16'h0, stall_count}, 32'(saved_stalls));

    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 32'h200, 1'b1, 32'h300);
    check("br_over_jump", pc, 32'h200);

    run(1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
    saved_stalls = int'(stall_count);
    run(1'b1, 1'b1, 1'b0, 32'h0BAD_0BAD);
    check("notready_pc", pc, 32'h204);
    check("notready_valid", {31'h0, if_id_valid}, 32'h0);
    check("notready_instr", if_id_instr, 32'h0);
    check("notready_stall", {16'h0, stall_count}, 32'(saved_stalls + 1));

    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    check("wrap_setup", pc, 32'hFFFF_FFFC);
    run(1'b1, 1'b1, 1'b1, 32'h0123_4567);
    check("wrap_pc", pc, 32'h0);
    check("wrap_pc4", if_id_pc4, 32'h0);
    check("wrap_valid", {31'h0, if_id_valid}, 32'h1);

    saved_instr = if_id_instr;
    run(1'b1, 1'b0, 1'b1, 32'h7777_7777);
    check("illegal_pc", pc, 32'h4);
    check("illegal_instr", if_id_instr, saved_instr);

    run(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0);
    check("midstall_reset_stall", {16'h0, stall_count}, 32'h0);
    check("midstall_reset_pc", pc, 32'h0);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 3, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) != 0, $urandom,
           $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 7) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset (bits [1:0] zero).
REQ-002 SHALL have clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have pc_write  input  1  from the hazard detection unit; 0 = hold PC.
REQ-005 SHALL have if_id_write  input  1  from the hazard detection unit; 0 = hold IF/ID.
REQ-006 SHALL have branch_taken  input  1  redirect request from EX.
REQ-007 SHALL have branch_target  input  32  redirect address for branch_taken.
REQ-008 SHALL have jump  input  1  redirect request from ID.
REQ-009 SHALL have jump_target  input  32  redirect address for jump.
REQ-010 SHALL have imem_addr  output  32  instruction memory address; equals pc combinationally.
REQ-011 SHALL have imem_rdata  input  32  instruction word for imem_addr, valid when imem_ready=1.
REQ-012 SHALL have imem_ready  input  1  1 = imem_rdata valid this cycle.
REQ-013 SHALL have pc  output  32  current fetch PC register.
REQ-014 SHALL have if_id_instr  output  32  IF/ID instruction register.
REQ-015 SHALL have if_id_pc4  output  32  IF/ID PC+4 register.
REQ-016 SHALL have if_id_valid  output  1  1 = IF/ID holds a real instruction.
REQ-017 SHALL have if_id_rs  output  5  if_id_instr[25:21], combinational.
REQ-018 SHALL have if_id_rt  output  5  if_id_instr[20:16], combinational.
REQ-019 SHALL have stall_count  output  16  saturating count of cycles in which the PC did not advance.

Function
REQ-020 SHALL compute the next PC with priority: reset > branch_taken > jump > hold (pc_write=0 or imem_ready=0) > pc+4.
REQ-021 SHALL load redirect targets with bits [1:0] forced to 0.
REQ-022 SHALL wrap pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 SHALL take a redirect even when pc_write=0 or imem_ready=0, abandoning the in-flight fetch.
REQ-024 SHALL, on branch_taken or jump, load IF/ID with instr=32'h0000_0000, valid=0, pc4=0 (flush).
REQ-025 SHALL, without a redirect and with if_id_write=0, hold all IF/ID registers unchanged.
REQ-026 SHALL, without a redirect, with if_id_write=1 and imem_ready=0, load an IF/ID bubble (instr=0, valid=0, pc4=0).
REQ-027 SHALL, without a redirect, with if_id_write=1 and imem_ready=1, load instr=imem_rdata, pc4=pc+4, valid=1.
REQ-028 SHALL treat pc_write=1 with if_id_write=0 as illegal; behaviour is the PC advancing while IF/ID holds (no assertion inside the block).
REQ-029 SHALL increment stall_count in each non-reset cycle in which the PC holds, excluding redirect cycles; it saturates at 16'hFFFF.
REQ-030 SHALL have a fetch latency of one cycle: an instruction present on imem_rdata with imem_ready=1 appears on if_id_instr the next cycle.

Reset
REQ-031 SHALL, in any cycle with reset=1, load pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, stall_count=0, overriding all other inputs.
REQ-032 SHALL, when reset is asserted mid-stall or during a redirect, discard both with no residual state.
REQ-033 SHALL present imem_addr=RESET_PC in the first cycle after reset is released.

Verification
REQ-034 SHALL pass this check: reset, then imem_ready=1, pc_write=if_id_write=1 for 3 cycles -> pc = 0,4,8,12 and if_id_pc4 = 4,8,12 with valid=1.
REQ-035 SHALL pass this check: pc=0x10 with pc_write=if_id_write=0 for 2 cycles -> pc stays 0x10, IF/ID unchanged, stall_count +2.
REQ-036 SHALL pass this check: branch_taken=1, branch_target=0x103, with pc_write=0 in the same cycle -> pc=0x100 next cycle, if_id_valid=0, if_id_instr=0.
REQ-037 SHALL pass this check: branch_taken=1 (target 0x200) and jump=1 (target 0x300) together -> pc=0x200.
REQ-038 SHALL pass this check: imem_ready=0 for 1 cycle with if_id_write=1 -> pc holds, IF/ID bubble loaded (valid=0), stall_count +1.
REQ-039 SHALL pass this check: pc=32'hFFFF_FFFC with imem_ready=1 -> pc=0 next cycle and if_id_pc4=0 with valid=1.
